// File: rtl/poly_ram_ctrl_if.sv
// Host/engine-facing bus of poly_ram_ctrl: command, load stream, unload stream and NTT RAM port.
// master = host + NTT engine side, slave = the RAM controller.
interface poly_ram_ctrl_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        busy;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        ntt_start;
    logic        ntt_inverse;
    logic        ntt_done;
    logic        ntt_wea;
    logic        ntt_web;
    logic [8:0]  ntt_addra;
    logic [8:0]  ntt_addrb;
    logic [15:0] ntt_dia;
    logic [15:0] ntt_dib;
    logic [15:0] ntt_doa;
    logic [15:0] ntt_dob;

    modport master (
        output cmd_valid, cmd_op, in_valid, in_data, out_ready,
               ntt_done, ntt_wea, ntt_web, ntt_addra, ntt_addrb, ntt_dia, ntt_dib,
        input  cmd_ready, busy, in_ready, out_valid, out_data, out_last,
               ntt_start, ntt_inverse, ntt_doa, ntt_dob
    );

    modport slave (
        input  cmd_valid, cmd_op, in_valid, in_data, out_ready,
               ntt_done, ntt_wea, ntt_web, ntt_addra, ntt_addrb, ntt_dia, ntt_dib,
        output cmd_ready, busy, in_ready, out_valid, out_data, out_last,
               ntt_start, ntt_inverse, ntt_doa, ntt_dob
    );
endinterface

// File: rtl/poly_ram_ctrl.sv
// 512x16 polynomial RAM owner: LOAD / RUN (NTT engine owns both ports) / UNLOAD via 2-entry FIFO.
// Define POLY_RAM_REDUCE_EN to subtract Q from unloaded coefficients >= Q.
module poly_ram_ctrl #(
    parameter int DEPTH = 512,
    parameter int Q     = 12289
) (
    input  logic           clk,
    input  logic           rst,
    poly_ram_ctrl_if.slave bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [15:0]   QW   = 16'(Q);
`ifdef POLY_RAM_REDUCE_EN
    localparam bit RED_EN = 1'b1;
`else
    localparam bit RED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_UNLOAD} state_t;

    state_t        r_state, w_next;
    logic [15:0]   r_mem [DEPTH];
    logic [15:0]   r_doa, r_dob;
    logic [AW-1:0] r_ptr;
    logic          r_issued_all;
    logic          r_rd_vld, r_rd_last;
    logic [15:0]   r_fd [2];
    logic          r_fl [2];
    logic          r_rp, r_wp;
    logic [1:0]    r_cnt;
    logic          r_start, r_inv;

    logic          w_run, w_cmd_acc, w_load_we, w_pop, w_issue, w_last_beat;
    logic          w_a_we, w_b_we;
    logic [AW-1:0] w_a_addr;
    logic [15:0]   w_a_di, w_cap;
    logic [2:0]    w_occ;

    assign w_run     = (r_state == S_RUN) & ~rst;
    assign w_cmd_acc = bus.cmd_valid & bus.cmd_ready;
    assign w_load_we = (r_state == S_LOAD) & bus.in_valid & ~rst;
    assign w_pop     = bus.out_valid & bus.out_ready;
    // Counting the beat leaving this cycle keeps a read in flight every cycle at full rate.
    assign w_occ       = {2'b0, r_rd_vld} + {1'b0, r_cnt} - {2'b0, w_pop};
    assign w_issue     = (r_state == S_UNLOAD) & ~r_issued_all & (w_occ < 3'd2);
    assign w_last_beat = w_pop & r_fl[r_rp];

    assign w_a_we   = w_run ? bus.ntt_wea   : w_load_we;
    assign w_a_addr = w_run ? bus.ntt_addra : r_ptr;
    assign w_a_di   = w_run ? bus.ntt_dia   : bus.in_data;
    assign w_b_we   = w_run & bus.ntt_web;
    assign w_cap    = (RED_EN && r_doa >= QW) ? r_doa - QW : r_doa;

    // Read-first on both ports; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_a_we) r_mem[w_a_addr] <= w_a_di;
        if (w_b_we) r_mem[bus.ntt_addrb] <= bus.ntt_dib;
        r_doa <= r_mem[w_a_addr];
        r_dob <= r_mem[bus.ntt_addrb];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_cmd_acc) begin
                case (bus.cmd_op)
                    2'd0:    w_next = S_LOAD;
                    2'd3:    w_next = S_UNLOAD;
                    default: w_next = S_RUN;
                endcase
            end
            S_LOAD:   if (w_load_we && r_ptr == LAST) w_next = S_IDLE;
            S_RUN:    if (bus.ntt_done) w_next = S_IDLE;
            S_UNLOAD: if (w_last_beat) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready   = (r_state == S_IDLE) & ~rst;
        bus.busy        = (r_state != S_IDLE);
        bus.in_ready    = (r_state == S_LOAD);
        bus.ntt_start   = r_start;
        bus.ntt_inverse = (r_state == S_RUN) & r_inv;
        bus.ntt_doa     = (r_state == S_RUN) ? r_doa : 16'd0;
        bus.ntt_dob     = (r_state == S_RUN) ? r_dob : 16'd0;
        bus.out_valid   = (r_state == S_UNLOAD) & (r_cnt != 2'd0);
        bus.out_data    = bus.out_valid ? r_fd[r_rp] : 16'd0;
        bus.out_last    = bus.out_valid & r_fl[r_rp];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_issued_all <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rp         <= 1'b0;
            r_wp         <= 1'b0;
            r_cnt        <= 2'd0;
            r_start      <= 1'b0;
            r_inv        <= 1'b0;
        end else begin
            r_start <= (r_state == S_IDLE) & w_cmd_acc & (bus.cmd_op == 2'd1 || bus.cmd_op == 2'd2);
            if (r_state == S_IDLE && w_cmd_acc) r_inv <= (bus.cmd_op == 2'd2);
            if (w_next != r_state) begin
                r_ptr        <= '0;
                r_issued_all <= 1'b0;
            end else begin
                if (w_load_we || w_issue) r_ptr <= r_ptr + 1'b1;
                if (w_issue && r_ptr == LAST) r_issued_all <= 1'b1;
            end
            r_rd_vld  <= w_issue;
            r_rd_last <= w_issue & (r_ptr == LAST);
            if (r_rd_vld) begin
                r_fd[r_wp] <= w_cap;
                r_fl[r_wp] <= r_rd_last;
                r_wp       <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_poly_ram_ctrl.sv
// Directed bench for poly_ram_ctrl: load/unload streams, NTT run handoff, reset recovery, reduction.
module tb_poly_ram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_ram_ctrl_if bus();
    poly_ram_ctrl #(.DEPTH(512), .Q(12289)) dut (.clk(clk), .rst(rst), .bus(bus));

    int npass = 0;
    int nfail = 0;
    int nchk  = 0;
    logic [15:0] model [512];

    task automatic chkb(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin nfail++; $error("FAIL %s: got %0b expected %0b", tag, obs, exp); end
    endtask

    task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin nfail++; $error("FAIL %s: got %0d expected %0d", tag, obs, exp); end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin nfail++; $error("FAIL %s: got %0d expected %0d", tag, obs, exp); end
    endtask

    function automatic logic [15:0] red(input logic [15:0] x);
`ifdef POLY_RAM_REDUCE_EN
        return (x >= 16'd12289) ? x - 16'd12289 : x;
`else
        return x;
`endif
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0;
        bus.in_valid = 1'b0;  bus.in_data = 16'd0;
        bus.out_ready = 1'b0; bus.ntt_done = 1'b0;
        bus.ntt_wea = 1'b0;   bus.ntt_web = 1'b0;
        bus.ntt_addra = 9'd0; bus.ntt_addrb = 9'd0;
        bus.ntt_dia = 16'd0;  bus.ntt_dib = 16'd0;
    endtask

    // Called at a negedge while idle; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [1:0] op);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // kind 0: value = index; kind 1: 12290, 12288, then 3*index.
    task automatic do_load(input int kind);
        logic [15:0] v;
        send_cmd(2'd0);
        chkb("load_ready_first", bus.in_ready, 1'b1);
        for (int i = 0; i < 512; i++) begin
            if (kind == 0) v = 16'(i);
            else if (i == 0) v = 16'd12290;
            else if (i == 1) v = 16'd12288;
            else v = 16'(3 * i);
            bus.in_valid = 1'b1;
            bus.in_data  = v;
            model[i]     = v;
            if (kind == 0 && i == 10) begin
                bus.ntt_wea = 1'b1; bus.ntt_addra = 9'd7; bus.ntt_dia = 16'hDEAD;
            end
            if (kind == 0 && i == 20) bus.ntt_done = 1'b1;
            if (i == 511) chkb("load_ready_last", bus.in_ready, 1'b1);
            @(negedge clk);
            bus.ntt_wea = 1'b0; bus.ntt_done = 1'b0;
        end
        bus.in_valid = 1'b0;
        chkb("load_done_in_ready", bus.in_ready, 1'b0);
        chkb("load_done_cmd_ready", bus.cmd_ready, 1'b1);
    endtask

    task automatic do_unload(input bit rnd);
        int idx = 0;
        int cyc = 0;
        send_cmd(2'd3);
        chkb("unload_busy", bus.busy, 1'b1);
        chkb("unload_valid_c1", bus.out_valid, 1'b0);
        @(negedge clk);
        chkb("unload_valid_c2", bus.out_valid, 1'b0);
        @(negedge clk);
        chkb("unload_valid_c3", bus.out_valid, 1'b1);
        while (idx < 512 && cyc < 4000) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rnd) chkb("unload_no_bubble", bus.out_valid, 1'b1);
            if (bus.out_valid) begin
                chkw("unload_data", bus.out_data, red(model[idx]));
                chkb("unload_last", bus.out_last, idx == 511);
                if (bus.out_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        chki("unload_beat_count", idx, 512);
        chkb("unload_end_valid", bus.out_valid, 1'b0);
        chkb("unload_end_cmd_ready", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chkb("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chkb("rst_busy", bus.busy, 1'b0);
        chkb("rst_in_ready", bus.in_ready, 1'b0);
        chkb("rst_out_valid", bus.out_valid, 1'b0);
        chkb("rst_ntt_start", bus.ntt_start, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chkb("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

        // Completion pulse while idle must be ignored.
        bus.ntt_done = 1'b1;
        @(negedge clk);
        bus.ntt_done = 1'b0;
        chkb("idle_done_busy", bus.busy, 1'b0);
        chkb("idle_done_cmd_ready", bus.cmd_ready, 1'b1);

        do_load(0);
        do_unload(1'b0);

        send_cmd(2'd1);
        chkb("fwd_start", bus.ntt_start, 1'b1);
        chkb("fwd_inverse", bus.ntt_inverse, 1'b0);
        bus.ntt_done = 1'b1;
        @(negedge clk);
        bus.ntt_done = 1'b0;
        chkb("fwd_cmd_ready", bus.cmd_ready, 1'b1);

        send_cmd(2'd2);
        chkb("inv_start", bus.ntt_start, 1'b1);
        chkb("inv_inverse", bus.ntt_inverse, 1'b1);
        bus.ntt_web = 1'b1; bus.ntt_addrb = 9'd5; bus.ntt_dib = 16'hABCD;
        bus.ntt_addra = 9'd3;
        @(negedge clk);
        bus.ntt_web = 1'b0;
        chkb("inv_start_once", bus.ntt_start, 1'b0);
        chkb("inv_inverse_held", bus.ntt_inverse, 1'b1);
        chkw("inv_doa", bus.ntt_doa, 16'd3);
        @(negedge clk);
        chkw("inv_dob", bus.ntt_dob, 16'hABCD);
        model[5] = 16'hABCD;
        bus.ntt_done = 1'b1;
        @(negedge clk);
        bus.ntt_done = 1'b0;
        chkb("inv_cmd_ready", bus.cmd_ready, 1'b1);
        chkb("inv_inverse_drop", bus.ntt_inverse, 1'b0);

        do_unload(1'b1);

        // Reset after 100 load beats.
        send_cmd(2'd0);
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(1000 + i);
            model[i]     = 16'(1000 + i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chkb("rst_load_in_ready", bus.in_ready, 1'b0);
        chkb("rst_load_busy", bus.busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chkb("rst_load_cmd_ready", bus.cmd_ready, 1'b1);

        do_load(1);
        do_unload(1'b1);

        // Reset with beats sitting in the FIFO.
        send_cmd(2'd3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chkb("rst_unload_pre_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chkb("rst_unload_valid", bus.out_valid, 1'b0);
        chkb("rst_unload_busy", bus.busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chkb("rst_unload_cmd_ready", bus.cmd_ready, 1'b1);
        do_unload(1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
